spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   Single-word SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, 32-bit frames.
//   Accepts a word on a valid/ready handshake, drives cs_n/sclk/mosi, and captures miso.
//   Presents the received word on a valid/ready handshake. It is the host-side
//   counterpart of spi_slave and shares that block's pin and handshake style.
// PARAMETERS
//   CLK_DIV   4  clk cycles per sclk half-period; legal >=2, and >=4 when driving spi_slave (2-flop sync)
//   CS_SETUP  2  clk cycles from cs_n fall to start of first sclk low phase; legal >=1
//   CS_HOLD   2  clk cycles from last sclk fall to cs_n rise; legal >=1
//   CS_IDLE   4  minimum clk cycles cs_n stays high between frames; legal >=1
// PORTS
//   clk       in   1   system clock
//   rst       in   1   asynchronous reset, active-high
//   tx_data   in   32  word to shift out
//   tx_valid  in   1   tx_data valid
//   tx_ready  out  1   block can accept a word
//   rx_data   out  32  word shifted in from miso
//   rx_valid  out  1   rx_data valid; held until rx_ready
//   rx_ready  in   1   consumer accepts rx_data
//   busy      out  1   high from accept until return to IDLE
//   sclk      out  1   SPI clock, idles low
//   mosi      out  1   SPI data out
//   miso      in   1   SPI data in; external-pin synchronisation is done outside this block
//   cs_n      out  1   chip select, active-low
// BEHAVIOUR
//   - All outputs are registered. Reset values: tx_ready=0, rx_data=0, rx_valid=0,
//     busy=0, sclk=0, mosi=0, cs_n=1.
//   - The state machine resets to IDLE. Asserting rst mid-frame aborts the frame
//     immediately: cs_n=1, sclk=0, no rx_valid.
//   - tx_ready=1 only in IDLE and only when !(rx_valid && !rx_ready). A pending
//     unread word blocks new frames, so overrun cannot occur.
//   - tx_ready rises the first cycle after rst deasserts.
//   - Accept occurs when tx_valid && tx_ready at edge T0. tx_data is latched into the
//     shift register at T0. At T0 the outputs go tx_ready=0, busy=1, cs_n=0,
//     mosi=tx_data[31]. The FSM enters SETUP.
//   - States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//   - SETUP: lasts CS_SETUP cycles with sclk=0, then goes to XFER.
//   - XFER, per bit i = 31..0: low phase of CLK_DIV cycles, then high phase of CLK_DIV
//     cycles. sclk rises at T0+CS_SETUP+CLK_DIV for bit 31.
//   - At each sclk fall the block samples miso into the rx shift register (MSB first).
//     In the same cycle mosi advances to the next bit. After the 32nd fall mosi holds
//     its last value.
//   - A bit counter (6 bits) counts sclk falls. At count 32 the FSM goes to HOLD.
//     On that same edge rx_data is loaded and rx_valid=1.
//   - HOLD: lasts CS_HOLD cycles with sclk=0 and cs_n=0, then cs_n=1 and the FSM
//     enters GAP.
//   - GAP: lasts CS_IDLE cycles with cs_n=1 and mosi=0. On exit busy=0 and the FSM
//     goes to IDLE.
//   - Frame length is fixed: cs_n is low for exactly CS_SETUP+64*CLK_DIV+CS_HOLD
//     cycles, and the frame has exactly 32 sclk rising edges.
//   - rx_valid clears on the cycle after rx_valid && rx_ready. rx_data is stable
//     while rx_valid=1.
//   - rx_ready asserted in the same cycle rx_valid rises consumes the word on the
//     next edge.
//   - tx_valid is ignored while busy. tx_data is sampled only at accept; later
//     changes have no effect on the frame in progress.
//   - Back-to-back: if tx_valid is held high, the next accept happens on the first
//     IDLE cycle after GAP. The minimum frame-to-frame period is then
//     1+CS_SETUP+64*CLK_DIV+CS_HOLD+CS_IDLE cycles.
//   - Each frame is sent exactly as defined above: no partial frames, and cs_n never
//     glitches low outside a frame.
// TESTING
//   (defaults CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4)
//   1. Loopback (miso=mosi), send 0xA5A50F0F -> rx_data=0xA5A50F0F; 32 sclk rises;
//      cs_n low for 260 cycles.
//   2. Mode-0 slave model returns 0x12345678 while master sends 0xDEADBEEF
//      -> model captures 0xDEADBEEF, rx_data=0x12345678.
//   3. Hold rx_ready=0 after frame 1 with tx_valid=1 -> tx_ready stays 0, no second
//      cs_n fall; raise rx_ready -> second frame starts, rx_valid pulses again.
//   4. tx_valid held high, 3 words queued -> cs_n high >=4 cycles between frames;
//      rx_valid asserted once per frame.
//   5. Assert rst during bit 10 -> same cycle cs_n=1, sclk=0, busy=0; no rx_valid;
//      next frame after reset is correct.
//   6. Change tx_data mid-frame and drive miso=1 constantly -> mosi shows the
//      originally latched word; rx_data=0xFFFFFFFF.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator: mode 0 (CPOL=0, CPHA=0), MSB first, fixed 32-bit frames.
// Word-level valid/ready handshakes on both the transmit and receive sides.
module spi_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        cs_n
);

   localparam int unsigned CntW = 16;
   localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
   localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
   localparam logic [CntW-1:0] IdleLast  = CntW'(CS_IDLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StXfer,
      StHold,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic [31:0]     tx_sr_q, tx_sr_d;
   logic [31:0]     rx_sr_q, rx_sr_d;
   logic [31:0]     rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            tx_ready_q, tx_ready_d;
   logic            busy_q, busy_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            cs_n_q, cs_n_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      busy_d     = busy_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (tx_valid && tx_ready_q) begin
               state_d   = StSetup;
               cnt_d     = '0;
               bit_cnt_d = '0;
               tx_sr_d   = tx_data;
               mosi_d    = tx_data[31];
               busy_d    = 1'b1;
               cs_n_d    = 1'b0;
            end
         end

         StSetup: begin
            if (cnt_q == SetupLast) begin
               state_d = StXfer;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StXfer: begin
            if (cnt_q != DivLast) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: capture miso and advance mosi in the same cycle.
                  sclk_d    = 1'b0;
                  rx_sr_d   = (rx_sr_q << 1) | {31'b0, miso};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_d == 6'd32) begin
                     state_d    = StHold;
                     rx_data_d  = rx_sr_d;
                     rx_valid_d = 1'b1;
                  end else begin
                     tx_sr_d = tx_sr_q << 1;
                     mosi_d  = tx_sr_q[30];
                  end
               end
            end
         end

         StHold: begin
            if (cnt_q == HoldLast) begin
               state_d = StGap;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StGap: begin
            if (cnt_q == IdleLast) begin
               state_d = StIdle;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // A pending unread word blocks the next accept, so overrun is impossible.
      tx_ready_d = (state_d == StIdle) && !rx_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: scoreboard of expected receive words, a mode-0 target
// model on the pins, and a pin monitor measuring frame timing.
module tb_spi_master;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned CS_SETUP  = 2;
   localparam int unsigned CS_HOLD   = 2;
   localparam int unsigned CS_IDLE   = 4;
   localparam int unsigned FRAME_LOW = CS_SETUP + 64 * CLK_DIV + CS_HOLD;
   localparam int          LIMIT     = 3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b1;
   logic        busy;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        cs_n;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];

   // 0: loopback, 1: target model, 2: constant one
   int          miso_mode = 0;
   logic [31:0] slave_word = '0;
   logic [31:0] slave_rx_sr = '0;
   int          slave_falls = 0;
   int          falls_at_cs = 0;
   int          slave_k;

   int cs_falls = 0, low_len = 0, last_low_len = 0, gap_len = 0, last_gap_len = 0;
   int sclk_rises = 0, rx_rises = 0;
   logic cs_n_prev = 1'b1, sclk_prev = 1'b0, rx_valid_prev = 1'b0;

   spi_master #(
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_IDLE (CS_IDLE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .busy    (busy),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
      .cs_n    (cs_n)
   );

   always #5 clk = ~clk;

   // Mode-0 target: shifts out on sclk fall, captures mosi on sclk rise.
   always @(negedge sclk) slave_falls <= slave_falls + 1;
   always @(negedge cs_n) falls_at_cs <= slave_falls;
   always @(posedge sclk) slave_rx_sr <= {slave_rx_sr[30:0], mosi};

   always_comb begin
      slave_k = slave_falls - falls_at_cs;
      case (miso_mode)
         0:       miso = mosi;
         1:       miso = (slave_k >= 0 && slave_k < 32) ? slave_word[31 - slave_k] : 1'b0;
         default: miso = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (cs_n_prev && !cs_n) begin
         cs_falls     <= cs_falls + 1;
         last_gap_len <= gap_len;
         low_len      <= 1;
      end else if (!cs_n) begin
         low_len <= low_len + 1;
      end
      if (!cs_n_prev && cs_n) begin
         last_low_len <= low_len;
         gap_len      <= 1;
      end else if (cs_n) begin
         gap_len <= gap_len + 1;
      end
      if (!sclk_prev && sclk) sclk_rises <= sclk_rises + 1;
      if (!rx_valid_prev && rx_valid) rx_rises <= rx_rises + 1;
      cs_n_prev     <= cs_n;
      sclk_prev     <= sclk;
      rx_valid_prev <= rx_valid;
   end

   // Called at a negedge; returns one negedge after the accepting posedge.
   task automatic send_word(input logic [31:0] w, output bit ok);
      int i = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (!tx_ready && i < LIMIT) begin
         @(negedge clk);
         i++;
      end
      ok = tx_ready;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_rx(output bit ok);
      int i = 0;
      while (!rx_valid && i < LIMIT) begin
         @(negedge clk);
         i++;
      end
      ok = rx_valid;
   endtask

   task automatic wait_idle(output bit ok);
      int i = 0;
      while (busy && i < LIMIT) begin
         @(negedge clk);
         i++;
      end
      ok = !busy;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({tx_ready, busy, sclk, mosi, cs_n, rx_valid} !== 6'b000010) begin
         $display("FAIL reset_outputs: got %b want 000010",
                  {tx_ready, busy, sclk, mosi, cs_n, rx_valid});
      end else n_pass++;
      n_checks++;
      if (rx_data !== 32'h0) $display("FAIL reset_rx_data: got %h want 0", rx_data);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready_rise: got %b want 1", tx_ready);
      else n_pass++;
   endtask

   task automatic test_loopback();
      bit ok;
      logic [31:0] w = 32'hA5A50F0F;
      logic [31:0] e;
      int r0;
      miso_mode = 0;
      r0 = sclk_rises;
      send_word(w, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL loop_accept: got %b want 1", ok);
      else n_pass++;
      exp_q.push_back(w);
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL loop_rx: got %h want %h", rx_data, e);
      else n_pass++;
      wait_idle(ok);
      @(negedge clk);
      n_checks++;
      if (last_low_len !== FRAME_LOW)
         $display("FAIL loop_cs_low: got %0d want %0d", last_low_len, FRAME_LOW);
      else n_pass++;
      n_checks++;
      if (sclk_rises - r0 !== 32) $display("FAIL loop_rises: got %0d want 32", sclk_rises - r0);
      else n_pass++;
      n_checks++;
      if (slave_rx_sr !== w) $display("FAIL loop_mosi: got %h want %h", slave_rx_sr, w);
      else n_pass++;
   endtask

   task automatic test_slave_model();
      bit ok;
      logic [31:0] e;
      miso_mode  = 1;
      slave_word = 32'h12345678;
      send_word(32'hDEADBEEF, ok);
      exp_q.push_back(32'h12345678);
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL slave_rx: got %h want %h", rx_data, e);
      else n_pass++;
      wait_idle(ok);
      n_checks++;
      if (slave_rx_sr !== 32'hDEADBEEF)
         $display("FAIL slave_capture: got %h want deadbeef", slave_rx_sr);
      else n_pass++;
      miso_mode = 0;
   endtask

   task automatic test_rx_backpressure();
      bit ok;
      bit saw_ready = 1'b0;
      bit unstable = 1'b0;
      logic [31:0] e;
      int f0, rr0;
      int i = 0;
      rr0 = rx_rises;
      rx_ready = 1'b0;
      send_word(32'h0BADF00D, ok);
      exp_q.push_back(32'h0BADF00D);
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL bp_rx1: got %h want %h", rx_data, e);
      else n_pass++;
      f0       = cs_falls;
      tx_data  = 32'h600DCAFE;
      tx_valid = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (tx_ready) saw_ready = 1'b1;
         if (!rx_valid || rx_data !== e) unstable = 1'b1;
      end
      n_checks++;
      if (saw_ready !== 1'b0 || cs_falls !== f0)
         $display("FAIL bp_blocked: got ready=%b falls=%0d want ready=0 falls=%0d",
                  saw_ready, cs_falls, f0);
      else n_pass++;
      n_checks++;
      if (unstable !== 1'b0) $display("FAIL bp_rx_hold: got unstable=%b want 0", unstable);
      else n_pass++;
      rx_ready = 1'b1;
      while (!tx_ready && i < LIMIT) begin
         @(negedge clk);
         i++;
      end
      exp_q.push_back(32'h600DCAFE);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL bp_rx2: got %h want %h", rx_data, e);
      else n_pass++;
      wait_idle(ok);
      n_checks++;
      if (rx_rises - rr0 !== 2) $display("FAIL bp_pulses: got %0d want 2", rx_rises - rr0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] words[3];
      int rr0;
      bit ok;
      words[0] = 32'h01234567;
      words[1] = 32'h89ABCDEF;
      words[2] = 32'hF00F55AA;
      rr0 = rx_rises;
      fork
         begin
            tx_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
               int i = 0;
               tx_data = words[k];
               while (!tx_ready && i < LIMIT) begin
                  @(negedge clk);
                  i++;
               end
               n_checks++;
               if (tx_ready !== 1'b1) $display("FAIL b2b_accept%0d: got %b want 1", k, tx_ready);
               else n_pass++;
               exp_q.push_back(words[k]);
               @(negedge clk);
            end
            tx_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 3; k++) begin
               bit got;
               logic [31:0] e;
               wait_rx(got);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
               n_checks++;
               if (!got || rx_data !== e) $display("FAIL b2b_rx%0d: got %h want %h", k, rx_data, e);
               else n_pass++;
               if (k > 0) begin
                  n_checks++;
                  if (last_gap_len !== CS_IDLE + 1)
                     $display("FAIL b2b_gap%0d: got %0d want %0d", k, last_gap_len, CS_IDLE + 1);
                  else n_pass++;
               end
               @(negedge clk);
            end
         end
      join
      wait_idle(ok);
      n_checks++;
      if (rx_rises - rr0 !== 3) $display("FAIL b2b_pulses: got %0d want 3", rx_rises - rr0);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      bit ok;
      logic [31:0] e;
      int r0, rr0;
      int i = 0;
      r0  = sclk_rises;
      rr0 = rx_rises;
      send_word(32'hCAFEBABE, ok);
      // Bit 10 is the 22nd bit from the MSB.
      while (sclk_rises - r0 < 22 && i < LIMIT) begin
         @(negedge clk);
         i++;
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({cs_n, sclk, busy} !== 3'b100)
         $display("FAIL midrst_abort: got cs_n,sclk,busy=%b want 100", {cs_n, sclk, busy});
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      n_checks++;
      if (rx_rises - rr0 !== 0) $display("FAIL midrst_no_rx: got %0d want 0", rx_rises - rr0);
      else n_pass++;
      send_word(32'h3C3C00FF, ok);
      exp_q.push_back(32'h3C3C00FF);
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL midrst_next_rx: got %h want %h", rx_data, e);
      else n_pass++;
      wait_idle(ok);
      @(negedge clk);
      n_checks++;
      if (last_low_len !== FRAME_LOW)
         $display("FAIL midrst_next_cs_low: got %0d want %0d", last_low_len, FRAME_LOW);
      else n_pass++;
   endtask

   task automatic test_tx_data_change();
      bit ok;
      logic [31:0] e;
      logic [31:0] w = 32'h5A0FC381;
      miso_mode = 2;
      send_word(w, ok);
      tx_data = ~w;
      exp_q.push_back(32'hFFFFFFFF);
      wait_rx(ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_checks++;
      if (!ok || rx_data !== e) $display("FAIL chg_rx: got %h want %h", rx_data, e);
      else n_pass++;
      wait_idle(ok);
      n_checks++;
      if (slave_rx_sr !== w) $display("FAIL chg_mosi: got %h want %h", slave_rx_sr, w);
      else n_pass++;
      miso_mode = 0;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_slave_model();
      test_rx_backpressure();
      test_back_to_back();
      test_reset_midframe();
      test_tx_data_change();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
